// File: rtl/operand_delivery_queue.sv
// Operand delivery queue: buffers producer results and serialises each target into a reservation station
// request/ack handshake with retry and drop. Optional statistics counters under `ODQ_STATS_EN.
module operand_delivery_queue #(
    parameter int DEPTH      = 4,
    parameter int ACK_WINDOW = 2,
    parameter int MAX_RETRY  = 3,
    parameter int OPERAND_W  = 32,
    parameter int INSTR_W    = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [OPERAND_W-1:0]   enq_value,
    input  logic [1:0]             enq_tgt_vld,
    input  logic [2*INSTR_W-1:0]   enq_tgt_instr,
    input  logic [3:0]             enq_tgt_slot,
    output logic                   req_out,
    output logic [INSTR_W-1:0]     dest_instr_out,
    output logic [1:0]             dest_slot_out,
    output logic [OPERAND_W-1:0]   operand_out,
    input  logic                   ack_in,
    output logic                   drop_pulse,
    output logic                   busy
`ifdef ODQ_STATS_EN
    ,
    output logic [15:0]            stat_delivered,
    output logic [15:0]            stat_dropped
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WW  = (ACK_WINDOW > 1) ? $clog2(ACK_WINDOW) : 1;
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [WW-1:0]  WAIT_LAST = WW'(ACK_WINDOW - 1);
    localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);
    localparam logic [AW:0]    PTR_ONE   = (AW + 1)'(1);

    // Handshake: req_out is a one-cycle pulse carrying dest_instr_out/dest_slot_out/operand_out;
    // the station answers with ack_in exactly one cycle later, which is only honoured in WAIT.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    logic [OPERAND_W-1:0] mem_value [DEPTH];
    logic [1:0]           mem_vld   [DEPTH];
    logic [2*INSTR_W-1:0] mem_instr [DEPTH];
    logic [3:0]           mem_slot  [DEPTH];

    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    logic [1:0]  enq_vld_clean;

    state_t         state_q, state_d;
    logic           tgt_q, tgt_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [RCW-1:0] retry_q, retry_d;
    logic           req_d, drop_d, load, tgt_done;

    logic [AW-1:0]        head;
    logic [1:0]           head_vld;
    logic [INSTR_W-1:0]   sel_instr;
    logic [1:0]           sel_slot;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign enq_ready = !full;
    assign push      = enq_valid && !full;
    assign busy      = !empty || (state_q != S_IDLE);

    // Slot 3 is not addressable, so such targets are silently discarded on entry.
    assign enq_vld_clean[0] = enq_tgt_vld[0] && (enq_tgt_slot[1:0] != 2'd3);
    assign enq_vld_clean[1] = enq_tgt_vld[1] && (enq_tgt_slot[3:2] != 2'd3);

    assign head      = rd_ptr[AW-1:0];
    assign head_vld  = empty ? 2'b00 : mem_vld[head];
    assign sel_instr = tgt_d ? mem_instr[head][2*INSTR_W-1:INSTR_W] : mem_instr[head][INSTR_W-1:0];
    assign sel_slot  = tgt_d ? mem_slot[head][3:2] : mem_slot[head][1:0];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_value[wr_ptr[AW-1:0]] <= enq_value;
            mem_vld[wr_ptr[AW-1:0]]   <= enq_vld_clean;
            mem_instr[wr_ptr[AW-1:0]] <= enq_tgt_instr;
            mem_slot[wr_ptr[AW-1:0]]  <= enq_tgt_slot;
        end
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        wait_d   = wait_q;
        retry_d  = retry_q;
        req_d    = 1'b0;
        drop_d   = 1'b0;
        load     = 1'b0;
        pop      = 1'b0;
        tgt_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_vld != 2'b00) begin
                    state_d = S_REQ;
                    tgt_d   = !head_vld[0];
                    retry_d = '0;
                    req_d   = 1'b1;
                    load    = 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (ack_in) begin
                    tgt_done = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RCW'(1);
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end else begin
                        drop_d   = 1'b1;
                        tgt_done = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
                // Target 1 still pending after target 0 closes: keep the head and request it.
                if (tgt_done) begin
                    if (!tgt_q && head_vld[1]) begin
                        tgt_d   = 1'b1;
                        retry_d = '0;
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        load    = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            tgt_q          <= 1'b0;
            wait_q         <= '0;
            retry_q        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            req_out        <= 1'b0;
            drop_pulse     <= 1'b0;
            dest_instr_out <= '0;
            dest_slot_out  <= '0;
            operand_out    <= '0;
        end else if (flush) begin
            state_q    <= S_IDLE;
            tgt_q      <= 1'b0;
            wait_q     <= '0;
            retry_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            req_out    <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            wait_q     <= wait_d;
            retry_q    <= retry_d;
            req_out    <= req_d;
            drop_pulse <= drop_d;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (load) begin
                dest_instr_out <= sel_instr;
                dest_slot_out  <= sel_slot;
                operand_out    <= mem_value[head];
            end
        end
    end

`ifdef ODQ_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_delivered <= '0;
            stat_dropped   <= '0;
        end else if (!flush) begin
            if (state_q == S_WAIT && ack_in && stat_delivered != 16'hFFFF)
                stat_delivered <= stat_delivered + 16'd1;
            if (drop_d && stat_dropped != 16'hFFFF)
                stat_dropped <= stat_dropped + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_delivery_queue.sv
// Self-checking bench for operand_delivery_queue: directed timing scenarios plus randomized traffic
// compared against a per-target retry/drop reference model.
module tb_operand_delivery_queue;
    localparam int DEPTH = 4, ACK_WINDOW = 2, MAX_RETRY = 3, OW = 32, IW = 7;
    localparam int PW = IW + 2 + OW;
    localparam int M_ACK = 0, M_NEVER = 1, M_RAND = 2, M_MANUAL = 3, M_STALL = 4;

    typedef struct packed {
        logic [OW-1:0]        value;
        logic [1:0]           vld;
        logic [1:0][IW-1:0]   instr;
        logic [1:0][1:0]      slot;
    } ent_t;

    logic clk, rst_n, flush, enq_valid, enq_ready, req_out, ack_in, drop_pulse, busy;
    logic [OW-1:0]   enq_value, operand_out;
    logic [1:0]      enq_tgt_vld, dest_slot_out;
    logic [2*IW-1:0] enq_tgt_instr;
    logic [3:0]      enq_tgt_slot;
    logic [IW-1:0]   dest_instr_out;
`ifdef ODQ_STATS_EN
    logic [15:0] stat_delivered, stat_dropped;
`endif

    int total = 0, bad = 0, cyc = 0, drop_cnt = 0, acc_cnt = 0, last_enq = 0, ack_mode = M_ACK;
    bit ack_sched = 0, ack_force = 0, ack_now = 0, stall = 0;
    logic [PW-1:0] obs_q[$], exp_q[$];
    int obs_cyc[$], drop_cyc[$];
    bit ack_log[$];
    ent_t mdl_q[$];

    operand_delivery_queue #(.DEPTH(DEPTH), .ACK_WINDOW(ACK_WINDOW), .MAX_RETRY(MAX_RETRY),
                             .OPERAND_W(OW), .INSTR_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_value(enq_value), .enq_tgt_vld(enq_tgt_vld), .enq_tgt_instr(enq_tgt_instr),
        .enq_tgt_slot(enq_tgt_slot), .req_out(req_out), .dest_instr_out(dest_instr_out),
        .dest_slot_out(dest_slot_out), .operand_out(operand_out), .ack_in(ack_in),
        .drop_pulse(drop_pulse), .busy(busy)
`ifdef ODQ_STATS_EN
        , .stat_delivered(stat_delivered), .stat_dropped(stat_dropped)
`endif
    );

    // Clock / reset
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Station model: logs every request and decides whether to ack it in the next cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (req_out === 1'b1) begin
                case (ack_mode)
                    M_ACK:   ack_now = 1'b1;
                    M_RAND:  ack_now = ($urandom_range(0, 1) == 1);
                    M_STALL: ack_now = !stall;
                    default: ack_now = 1'b0;
                endcase
                obs_q.push_back({dest_instr_out, dest_slot_out, operand_out});
                obs_cyc.push_back(cyc);
                ack_log.push_back(ack_now);
                ack_sched = ack_now;
            end else begin
                ack_sched = 1'b0;
            end
            if (drop_pulse === 1'b1) begin
                drop_cnt++;
                drop_cyc.push_back(cyc);
            end
        end else begin
            ack_sched = 1'b0;
        end
    end
    always @(posedge clk) begin
        #2;
        ack_in = ack_sched | ack_force;
    end

    // Driver tasks
    task automatic do_reset();
        rst_n = 0; flush = 0; enq_valid = 0; enq_value = '0; enq_tgt_vld = '0;
        enq_tgt_instr = '0; enq_tgt_slot = '0; ack_force = 0; stall = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic enq(input ent_t e);
        bit rdy, done;
        int n;
        done = 0;
        n = 0;
        if (clk !== 1'b1) begin @(posedge clk); #1; end
        enq_valid = 1; enq_value = e.value; enq_tgt_vld = e.vld;
        enq_tgt_instr = e.instr; enq_tgt_slot = e.slot;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            rdy = enq_ready;
            n = cyc;
            @(posedge clk);
            if (rdy) begin done = 1; acc_cnt++; end
            #1;
        end
        enq_valid = 0;
        if (done) begin mdl_q.push_back(e); last_enq = n; end
        total++;
        if (!done) begin bad++; $display("FAIL enq_timeout enq_ready=%0b required=1", enq_ready); end
    endtask

    task automatic drain(input int bound, output bit to);
        to = 1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!busy && !req_out && !drop_pulse) begin to = 0; break; end
        end
        @(negedge clk);
    endtask

    // Reference model: each legal target is requested until acked, at most MAX_RETRY+1 times, else dropped.
    task automatic model_run(input int ob, output int e_drop, output int e_del);
        int k;
        bit got;
        k = 0; e_drop = 0; e_del = 0;
        exp_q.delete();
        foreach (mdl_q[i]) begin
            for (int t = 0; t < 2; t++) begin
                if (mdl_q[i].vld[t] && mdl_q[i].slot[t] != 2'd3) begin
                    for (int a = 0; a <= MAX_RETRY; a++) begin
                        exp_q.push_back({mdl_q[i].instr[t], mdl_q[i].slot[t], mdl_q[i].value});
                        got = (ob + k < ack_log.size()) ? ack_log[ob + k] : 1'b0;
                        k++;
                        if (got) begin e_del++; break; end
                        if (a == MAX_RETRY) e_drop++;
                    end
                end
            end
        end
    endtask

    function automatic ent_t rand_ent(input bit legal);
        ent_t e;
        e.value = $urandom;
        e.vld   = legal ? {1'($urandom_range(0, 1)), 1'b1} : 2'($urandom_range(0, 3));
        for (int t = 0; t < 2; t++) begin
            e.instr[t] = IW'($urandom_range(0, 127));
            e.slot[t]  = legal ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
        end
        return e;
    endfunction

    // Tests
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL rst_enq_ready got=%b exp=1", enq_ready); end
        total++; if (req_out !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", req_out); end
        total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b exp=0", drop_pulse); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if ({dest_instr_out, dest_slot_out, operand_out} !== '0) begin
            bad++; $display("FAIL rst_payload got=%h exp=0", {dest_instr_out, dest_slot_out, operand_out});
        end
    endtask

    task automatic test_single();
        ent_t e;
        int ob, n;
        ob = obs_q.size(); ack_mode = M_ACK;
        e = '0; e.value = 32'h55; e.vld = 2'b01; e.instr[0] = 7'd5; e.slot[0] = 2'd1;
        enq(e); n = last_enq;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cyc == n + 3) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_mid got=%b exp=1", busy); end
            end
            if (cyc == n + 4) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
                break;
            end
        end
        @(negedge clk);
        total++;
        if (obs_q.size() - ob != 1) begin
            bad++; $display("FAIL single_req_count got=%0d exp=1", obs_q.size() - ob);
        end else begin
            total++; if (obs_cyc[ob] != n + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", obs_cyc[ob], n + 2); end
            total++; if (obs_q[ob] !== {7'd5, 2'd1, 32'h55}) begin
                bad++; $display("FAIL single_payload got=%h exp=%h", obs_q[ob], {7'd5, 2'd1, 32'h55});
            end
        end
    endtask

    task automatic test_two_targets();
        ent_t e;
        int ob, n;
        ob = obs_q.size(); ack_mode = M_ACK;
        e.value = 32'hCAFE_0002; e.vld = 2'b11;
        e.instr[0] = 7'd5; e.slot[0] = 2'd0; e.instr[1] = 7'd9; e.slot[1] = 2'd2;
        enq(e); n = last_enq;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cyc == n + 5) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL two_busy_mid got=%b exp=1", busy); end
            end
            if (cyc == n + 6) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL two_busy_end got=%b exp=0", busy); end
                break;
            end
        end
        @(negedge clk);
        total++;
        if (obs_q.size() - ob != 2) begin
            bad++; $display("FAIL two_req_count got=%0d exp=2", obs_q.size() - ob);
        end else begin
            total++; if (obs_cyc[ob] != n + 2 || obs_cyc[ob + 1] != n + 4) begin
                bad++; $display("FAIL two_spacing got=%0d,%0d exp=%0d,%0d", obs_cyc[ob], obs_cyc[ob + 1], n + 2, n + 4);
            end
            total++; if (obs_q[ob] !== {7'd5, 2'd0, 32'hCAFE_0002}) begin
                bad++; $display("FAIL two_first got=%h exp=%h", obs_q[ob], {7'd5, 2'd0, 32'hCAFE_0002});
            end
            total++; if (obs_q[ob + 1] !== {7'd9, 2'd2, 32'hCAFE_0002}) begin
                bad++; $display("FAIL two_second got=%h exp=%h", obs_q[ob + 1], {7'd9, 2'd2, 32'hCAFE_0002});
            end
        end
    endtask

    task automatic test_retry_drop();
        ent_t a, b;
        int ob, db, n;
        ob = obs_q.size(); db = drop_cnt; ack_mode = M_NEVER;
        a = '0; a.value = 32'hA1; a.vld = 2'b01; a.instr[0] = 7'd7; a.slot[0] = 2'd1;
        b = '0; b.value = 32'hB2; b.vld = 2'b10; b.instr[1] = 7'd3; b.slot[1] = 2'd0;
        enq(a); n = last_enq;
        for (int k = 0; k < 60 && drop_cnt == db; k++) @(negedge clk);
        @(negedge clk);
        total++;
        if (obs_q.size() - ob != 4 || drop_cnt - db != 1) begin
            bad++; $display("FAIL retry_counts reqs=%0d drops=%0d exp reqs=4 drops=1", obs_q.size() - ob, drop_cnt - db);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (obs_cyc[ob + i] != n + 2 + 3 * i || obs_q[ob + i] !== {7'd7, 2'd1, 32'hA1}) begin
                    bad++; $display("FAIL retry_req%0d got cyc=%0d %h exp cyc=%0d %h", i, obs_cyc[ob + i],
                                    obs_q[ob + i], n + 2 + 3 * i, {7'd7, 2'd1, 32'hA1});
                end
            end
            total++; if (drop_cyc[db] != n + 14) begin
                bad++; $display("FAIL retry_drop_cycle got=%0d exp=%0d", drop_cyc[db], n + 14);
            end
        end
        ack_mode = M_ACK;
        enq(b);
        begin
            bit to;
            drain(100, to);
            total++; if (to) begin bad++; $display("FAIL retry_drain_timeout busy=%b exp=0", busy); end
        end
        total++; if (obs_q.size() - ob != 5 || obs_q[obs_q.size() - 1] !== {7'd3, 2'd0, 32'hB2}) begin
            bad++; $display("FAIL retry_next_entry reqs=%0d last=%h exp reqs=5 last=%h", obs_q.size() - ob,
                            obs_q[obs_q.size() - 1], {7'd3, 2'd0, 32'hB2});
        end
    endtask

    task automatic test_back_to_back();
        ent_t ents[5];
        int ob, db, e_drop, e_del;
        bit to;
        ob = obs_q.size(); db = drop_cnt; mdl_q.delete(); acc_cnt = 0;
        ack_mode = M_STALL; stall = 1;
        foreach (ents[i]) ents[i] = rand_ent(1'b1);
        fork
            begin
                for (int i = 0; i < 5; i++) enq(ents[i]);
            end
            begin
                for (int k = 0; k < 50 && acc_cnt < 4; k++) @(negedge clk);
                total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", enq_ready); end
                @(negedge clk);
                total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_ready_hold got=%b exp=0", enq_ready); end
                stall = 0;
            end
        join
        drain(1000, to);
        total++; if (to) begin bad++; $display("FAIL b2b_drain_timeout busy=%b exp=0", busy); end
        model_run(ob, e_drop, e_del);
        total++; if (mdl_q.size() != 5) begin bad++; $display("FAIL b2b_accepted got=%0d exp=5", mdl_q.size()); end
        total++; if (obs_q.size() - ob != exp_q.size()) begin
            bad++; $display("FAIL b2b_req_count got=%0d exp=%0d", obs_q.size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            total++; if (obs_q[ob + i] !== exp_q[i]) begin
                bad++; $display("FAIL b2b_req%0d got=%h exp=%h", i, obs_q[ob + i], exp_q[i]);
            end
        end
        total++; if (drop_cnt - db != e_drop) begin bad++; $display("FAIL b2b_drops got=%0d exp=%0d", drop_cnt - db, e_drop); end
    endtask

    task automatic test_flush();
        ent_t e, f;
        int ob, db;
        ob = obs_q.size(); db = drop_cnt; ack_mode = M_MANUAL;
        e = '0; e.value = 32'hF1; e.vld = 2'b01; e.instr[0] = 7'd4; e.slot[0] = 2'd0;
        f = '0; f.value = 32'hF2; f.vld = 2'b01; f.instr[0] = 7'd8; f.slot[0] = 2'd1;
        enq(e);
        for (int k = 0; k < 10 && req_out !== 1'b1; k++) @(negedge clk);
        @(posedge clk); #1;
        flush = 1; enq_valid = 1; enq_value = f.value; enq_tgt_vld = f.vld;
        enq_tgt_instr = f.instr; enq_tgt_slot = f.slot;
        @(posedge clk); #1;
        flush = 0; enq_valid = 0; ack_force = 1;
        @(negedge clk);
        total++; if (req_out !== 1'b0) begin bad++; $display("FAIL flush_req got=%b exp=0", req_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
        total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", drop_pulse); end
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", enq_ready); end
        @(posedge clk); #1;
        ack_force = 0;
        repeat (15) @(negedge clk);
        total++; if (obs_q.size() - ob != 1 || drop_cnt != db || busy !== 1'b0) begin
            bad++; $display("FAIL flush_after reqs=%0d drops=%0d busy=%b exp reqs=1 drops=0 busy=0",
                            obs_q.size() - ob, drop_cnt - db, busy);
        end
    endtask

    task automatic test_no_targets();
        ent_t e;
        int ob, db, n;
        bit to;
        ob = obs_q.size(); db = drop_cnt; ack_mode = M_ACK;
        for (int v = 0; v < 2; v++) begin
            e = '0; e.value = 32'hD0 + v;
            e.vld = (v == 0) ? 2'b00 : 2'b01;
            e.slot[0] = (v == 0) ? 2'd1 : 2'd3;
            enq(e); n = last_enq;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (cyc == n + 1) begin
                    total++; if (busy !== 1'b1) begin bad++; $display("FAIL notgt%0d_busy_head got=%b exp=1", v, busy); end
                end
                if (cyc == n + 2) begin
                    total++; if (busy !== 1'b0) begin bad++; $display("FAIL notgt%0d_popped got=%b exp=0", v, busy); end
                    break;
                end
            end
        end
        e = '0; e.value = 32'hD7; e.vld = 2'b11; e.instr[0] = 7'd2; e.slot[0] = 2'd2;
        e.instr[1] = 7'd6; e.slot[1] = 2'd3;
        enq(e);
        drain(100, to);
        total++; if (to) begin bad++; $display("FAIL notgt_drain_timeout busy=%b exp=0", busy); end
        total++; if (obs_q.size() - ob != 1 || drop_cnt != db) begin
            bad++; $display("FAIL notgt_counts reqs=%0d drops=%0d exp reqs=1 drops=0", obs_q.size() - ob, drop_cnt - db);
        end else begin
            total++; if (obs_q[ob] !== {7'd2, 2'd2, 32'hD7}) begin
                bad++; $display("FAIL notgt_payload got=%h exp=%h", obs_q[ob], {7'd2, 2'd2, 32'hD7});
            end
        end
    endtask

    task automatic test_async_reset();
        ent_t e;
        ack_mode = M_MANUAL;
        e = '0; e.value = 32'h1234_5678; e.vld = 2'b01; e.instr[0] = 7'd11; e.slot[0] = 2'd1;
        enq(e);
        for (int k = 0; k < 10 && req_out !== 1'b1; k++) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        total++; if (req_out !== 1'b0 || busy !== 1'b0 || enq_ready !== 1'b1) begin
            bad++; $display("FAIL areset_ctrl req=%b busy=%b ready=%b exp 0 0 1", req_out, busy, enq_ready);
        end
        total++; if ({dest_instr_out, dest_slot_out, operand_out} !== '0) begin
            bad++; $display("FAIL areset_payload got=%h exp=0", {dest_instr_out, dest_slot_out, operand_out});
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int ob, db, e_drop, e_del;
        bit to;
        do_reset();
        @(negedge clk);
        ob = obs_q.size(); db = drop_cnt; mdl_q.delete(); ack_mode = M_RAND;
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            enq(rand_ent(1'b0));
        end
        drain(3000, to);
        total++; if (to) begin bad++; $display("FAIL rand_drain_timeout busy=%b exp=0", busy); end
        model_run(ob, e_drop, e_del);
        total++; if (obs_q.size() - ob != exp_q.size()) begin
            bad++; $display("FAIL rand_req_count got=%0d exp=%0d", obs_q.size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            total++; if (obs_q[ob + i] !== exp_q[i]) begin
                bad++; $display("FAIL rand_req%0d got=%h exp=%h", i, obs_q[ob + i], exp_q[i]);
            end
        end
        total++; if (drop_cnt - db != e_drop) begin bad++; $display("FAIL rand_drops got=%0d exp=%0d", drop_cnt - db, e_drop); end
`ifdef ODQ_STATS_EN
        total++; if (stat_delivered != 16'(e_del)) begin bad++; $display("FAIL stat_delivered got=%0d exp=%0d", stat_delivered, e_del); end
        total++; if (stat_dropped != 16'(e_drop)) begin bad++; $display("FAIL stat_dropped got=%0d exp=%0d", stat_dropped, e_drop); end
`endif
    endtask

    initial begin
        ack_in = 0;
        test_reset();
        test_single();
        test_two_targets();
        test_retry_drop();
        test_back_to_back();
        test_flush();
        test_no_targets();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
